bus_responder: RTL and testbench
================================

Name: bus_responder

Overview:
- CPU-side completion logic for the memory/peripheral bus.
- Takes the per-device enable vector from the address decoder and the CPU's mem_valid. Forwards a one-hot request to the selected device, waits for that device's ready, then returns a single-cycle mem_ready with registered read data.
- Flags unmapped or timed-out accesses as bus errors so the CPU never hangs.

Parameters:
- NUM_DEV, 8, number of device slots; must equal decoder enable width.
- TIMEOUT, 16, cycles spent in WAIT without dev_ready before a timeout error is declared; legal range 1..255.
- ERR_RDATA, 32'h0000_0000, read data returned on any error response.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_valid  input  1  CPU request strobe; held high until mem_ready is seen.
- enables  input  NUM_DEV  decoder output; bit i selects device i.
- dev_ready  input  NUM_DEV  per-device completion strobe.
- dev_rdata  input  32*NUM_DEV  per-device read data, device i at bits [32*i+31:32*i].
- dev_valid  output  NUM_DEV  one-hot request to the selected device.
- mem_ready  output  1  one-cycle completion pulse to CPU.
- mem_rdata  output  32  registered read data.
- bus_error  output  1  qualifies mem_ready; 1 = unmapped or timeout.
- err_count  output  8  saturating count of error responses.

Behaviour:
- Reset (clk edge with reset=1) forces the following, overriding any in-flight transaction:
  - state=IDLE, dev_valid=0, mem_ready=0, mem_rdata=0, bus_error=0, err_count=0, timeout counter=0, sel_q=0.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states are IDLE, WAIT, RESP.
- IDLE:
  - When mem_valid=1, latch sel_q = lowest set bit of enables (priority to the lowest index if several bits are set).
  - If enables==0: go to RESP with error pending and rdata=ERR_RDATA.
  - Otherwise: go to WAIT, clear the counter, and drive dev_valid=onehot(sel_q) starting next cycle.
- WAIT:
  - dev_valid is held at onehot(sel_q) throughout.
  - If dev_ready[sel_q]=1: capture dev_rdata slice sel_q, set error pending=0, go to RESP.
  - Else if counter==TIMEOUT-1: error pending=1, rdata=ERR_RDATA, go to RESP.
  - Else: counter+1.
  - dev_ready bits of unselected devices are ignored.
  - enables and mem_valid are not re-sampled while in WAIT.
- RESP:
  - dev_valid=0, mem_ready=1 for exactly one cycle, mem_rdata and bus_error valid.
  - Always returns to IDLE next cycle.
  - mem_valid is ignored during RESP; the CPU drops it on the same edge.
- Latency:
  - Device ready in the first WAIT cycle: mem_ready is asserted 2 cycles after mem_valid is first sampled.
  - Unmapped access: mem_ready is asserted 1 cycle after mem_valid is first sampled.
  - Timeout: mem_ready is asserted TIMEOUT+1 cycles after mem_valid is first sampled.
- Back-to-back transactions: the minimum spacing is 3 cycles (IDLE, WAIT, RESP).
- mem_rdata holds its last value outside RESP. bus_error drops to 0 after RESP.
- err_count increments in each RESP cycle with bus_error=1 and saturates at 255; it does not wrap.
- Reads and writes are handled identically; rdata is captured regardless of direction.
- If dev_ready[sel_q] and the timeout condition occur in the same cycle, ready wins and no error is flagged.

Decomposition:
- Shared package bus_pkg holds:
  - State enum (IDLE, WAIT, RESP).
  - NUM_DEV default.
  - Device index constants (DEV_MEM=0, remaining slots reserved).
  - ERR_RDATA default.
- One natural sub-module: prio_onehot (lowest-set-bit one-hot plus index encoder), reused by the decoder side.
- Timeout counter and rdata mux stay inline.

Test Plan:
- After reset, all outputs are 0. mem_valid=1, enables=8'h01, dev_ready[0]=1 in the first WAIT cycle with rdata 32'h1234_5678 -> dev_valid=8'h01 for 1 cycle, then mem_ready=1 for 1 cycle with mem_rdata=32'h1234_5678 and bus_error=0.
- enables=8'h00 with mem_valid=1 -> mem_ready on the next cycle, bus_error=1, mem_rdata=0, err_count=1, dev_valid stays 0.
- enables=8'h02, device 1 never ready, TIMEOUT=16 -> dev_valid=8'h02 for 16 cycles, then mem_ready with bus_error=1; dev_ready[3]=1 asserted meanwhile is ignored.
- enables=8'h06, dev_ready[1]=1 after 3 WAIT cycles -> dev_valid=8'h02 (lowest index wins), mem_ready 5 cycles after request with device 1 data.
- Reset asserted in the 5th WAIT cycle -> next cycle all outputs are 0 and state is IDLE. A following good access completes normally with no spurious mem_ready.
- 260 unmapped accesses back to back -> err_count reaches 255 and stays there. dev_ready and timeout on the same cycle -> bus_error=0 with device data returned.

Source files
------------

// File: rtl/bus_responder_pkg.sv
// Shared constants for the CPU-side bus responder and the address decoder.
package bus_pkg;

   localparam int unsigned NUM_DEV_DEFAULT   = 8;
   localparam logic [31:0] ERR_RDATA_DEFAULT = 32'h0000_0000;

   // Device slot indices; only slot 0 is assigned, the rest are reserved.
   localparam int unsigned DEV_MEM = 0;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_responder_if.sv
// CPU request/response and per-device handshake bundle for bus_responder.
interface bus_responder_if #(
   parameter int unsigned NUM_DEV = bus_pkg::NUM_DEV_DEFAULT
);
   logic                    mem_valid;
   logic [NUM_DEV-1:0]      enables;
   logic [NUM_DEV-1:0]      dev_ready;
   logic [32*NUM_DEV-1:0]   dev_rdata;
   logic [NUM_DEV-1:0]      dev_valid;
   logic                    mem_ready;
   logic [31:0]             mem_rdata;
   logic                    bus_error;
   logic [7:0]              err_count;

   modport slave (
      input  mem_valid, enables, dev_ready, dev_rdata,
      output dev_valid, mem_ready, mem_rdata, bus_error, err_count
   );

   modport master (
      output mem_valid, enables, dev_ready, dev_rdata,
      input  dev_valid, mem_ready, mem_rdata, bus_error, err_count
   );
endinterface

// File: rtl/bus_responder_prio_onehot.sv
// Lowest-set-bit priority picker: one-hot grant, binary index and any-set flag.
module prio_onehot #(
   parameter int unsigned N  = 8,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);

   // Scan from the top down so the lowest set bit is the final assignment.
   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = |req;
      for (int unsigned i = N; i > 0; i--) begin
         if (req[i-1]) begin
            onehot      = '0;
            onehot[i-1] = 1'b1;
            idx         = IW'(i - 1);
         end
      end
   end

endmodule

// File: rtl/bus_responder.sv
// Completes CPU bus accesses: forwards a one-hot request, waits for the device
// (or a timeout), then returns a single-cycle mem_ready with registered data.
module bus_responder
   import bus_pkg::*;
#(
   parameter int unsigned NUM_DEV   = NUM_DEV_DEFAULT,
   parameter int unsigned TIMEOUT   = 16,
   parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   bus_responder_if.slave bus
);

   localparam int unsigned IW      = idx_width(NUM_DEV);
   localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

   logic [1:0]         state;
   logic [7:0]         cnt;
   logic [IW-1:0]      sel_q;
   logic [NUM_DEV-1:0] dev_valid;
   logic               mem_ready;
   logic [31:0]        mem_rdata;
   logic               bus_error;
   logic [7:0]         err_count;

   logic [NUM_DEV-1:0] pick_onehot;
   logic [IW-1:0]      pick_idx;
   logic               pick_any;
   logic               sel_ready;
   logic [31:0]        sel_rdata;

   prio_onehot #(.N(NUM_DEV), .IW(IW)) u_pick (
      .req    (bus.enables),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int unsigned i = 0; i < NUM_DEV; i++) begin
         if (sel_q == IW'(i)) begin
            sel_ready = bus.dev_ready[i];
            sel_rdata = bus.dev_rdata[32*i +: 32];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         sel_q     <= '0;
         dev_valid <= '0;
         mem_ready <= 1'b0;
         mem_rdata <= '0;
         bus_error <= 1'b0;
         err_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.mem_valid) begin
                  sel_q <= pick_idx;
                  cnt   <= '0;
                  if (!pick_any) begin
                     state     <= S_RESP;
                     mem_ready <= 1'b1;
                     bus_error <= 1'b1;
                     mem_rdata <= ERR_RDATA;
                  end else begin
                     state     <= S_WAIT;
                     dev_valid <= pick_onehot;
                  end
               end
            end
            // Ready is tested before the timeout so a same-cycle ready still succeeds.
            S_WAIT: begin
               if (sel_ready) begin
                  state     <= S_RESP;
                  dev_valid <= '0;
                  mem_ready <= 1'b1;
                  bus_error <= 1'b0;
                  mem_rdata <= sel_rdata;
               end else if (cnt == TO_LAST) begin
                  state     <= S_RESP;
                  dev_valid <= '0;
                  mem_ready <= 1'b1;
                  bus_error <= 1'b1;
                  mem_rdata <= ERR_RDATA;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_RESP: begin
               state     <= S_IDLE;
               mem_ready <= 1'b0;
               bus_error <= 1'b0;
               if (bus_error && err_count != 8'hFF)
                  err_count <= err_count + 8'd1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.dev_valid = dev_valid;
   assign bus.mem_ready = mem_ready;
   assign bus.mem_rdata = mem_rdata;
   assign bus.bus_error = bus_error;
   assign bus.err_count = err_count;

endmodule

// File: tb/tb_bus_responder.sv
// Randomized self-checking bench for bus_responder against a transaction-level model.
module tb_bus_responder;

   localparam int unsigned NDEV    = 8;
   localparam int unsigned TO      = 16;
   localparam logic [31:0] ERRDATA = 32'h0000_0000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_total = 0;
   int   n_bad = 0;
   int   err_model = 0;

   always #5 clk = ~clk;

   bus_responder_if #(.NUM_DEV(NDEV)) bif ();

   bus_responder #(
      .NUM_DEV   (NDEV),
      .TIMEOUT   (TO),
      .ERR_RDATA (ERRDATA)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // One CPU access. w = WAIT cycle (1-based) in which the selected device
   // raises ready; w <= 0 means the device never answers.
   task automatic do_txn(input logic [7:0] en, input int w);
      int          sel;
      int          lat;
      logic [31:0] data [NDEV];
      logic [31:0] exp_data;
      logic [31:0] last_data;
      logic        exp_err;
      logic [7:0]  noise;
      logic [7:0]  exp_valid;

      sel = -1;
      for (int i = 0; i < NDEV; i++)
         if (sel < 0 && en[i]) sel = i;
      for (int i = 0; i < NDEV; i++) begin
         data[i] = $urandom;
         bif.dev_rdata[32*i +: 32] = data[i];
      end

      if (sel < 0) begin
         lat = 1; exp_err = 1'b1; exp_data = ERRDATA;
      end else if (w >= 1 && w <= int'(TO)) begin
         lat = w + 1; exp_err = 1'b0; exp_data = data[sel];
      end else begin
         lat = TO + 1; exp_err = 1'b1; exp_data = ERRDATA;
      end

      last_data     = bif.mem_rdata;
      bif.mem_valid = 1'b1;
      bif.enables   = en;
      bif.dev_ready = '0;

      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         exp_valid = '0;
         if (sel >= 0 && c < lat) exp_valid[sel] = 1'b1;
         check_eq("dev_valid", 32'(bif.dev_valid), 32'(exp_valid));
         check_eq("mem_ready", 32'(bif.mem_ready), (c == lat) ? 32'd1 : 32'd0);
         if (c < lat)
            check_eq("rdata_hold", bif.mem_rdata, last_data);
         if (c == lat) begin
            check_eq("mem_rdata", bif.mem_rdata, exp_data);
            check_eq("bus_error", 32'(bif.bus_error), 32'(exp_err));
            check_eq("err_cnt_resp", 32'(bif.err_count), 32'(err_model));
            bif.mem_valid = 1'b0;
            bif.enables   = 8'($urandom);
            bif.dev_ready = 8'($urandom);
         end else begin
            noise = 8'($urandom);
            if (sel >= 0) noise[sel] = (c == w);
            bif.dev_ready = noise;
         end
      end

      if (exp_err) err_model = (err_model >= 255) ? 255 : err_model + 1;
      @(negedge clk);
      check_eq("ready_drop", 32'(bif.mem_ready), 32'd0);
      check_eq("error_drop", 32'(bif.bus_error), 32'd0);
      check_eq("rdata_kept", bif.mem_rdata, exp_data);
      check_eq("err_count", 32'(bif.err_count), 32'(err_model));
      bif.dev_ready = '0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_dev_valid"}, 32'(bif.dev_valid), 32'd0);
      check_eq({tag, "_mem_ready"}, 32'(bif.mem_ready), 32'd0);
      check_eq({tag, "_mem_rdata"}, bif.mem_rdata, 32'd0);
      check_eq({tag, "_bus_error"}, 32'(bif.bus_error), 32'd0);
      check_eq({tag, "_err_count"}, 32'(bif.err_count), 32'd0);
   endtask

   initial begin
      logic [7:0] en;
      int         w;

      bif.mem_valid = 1'b0;
      bif.enables   = '0;
      bif.dev_ready = '0;
      bif.dev_rdata = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_all_zero("reset");

      do_txn(8'h01, 1);
      do_txn(8'h00, 0);
      do_txn(8'h02, 0);
      do_txn(8'h06, 4);
      do_txn(8'h80, int'(TO));
      do_txn(8'h18, int'(TO) + 1);

      // Reset while the access is in its 5th WAIT cycle.
      bif.mem_valid = 1'b1;
      bif.enables   = 8'h04;
      bif.dev_ready = '0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset         = 1'b0;
      bif.mem_valid = 1'b0;
      err_model     = 0;
      check_all_zero("midreset");
      @(negedge clk);
      check_all_zero("idle_after_reset");
      do_txn(8'h04, 2);

      for (int t = 0; t < 150; t++) begin
         case ($urandom_range(0, 3))
            0:       en = 8'h00;
            1:       en = 8'h01 << $urandom_range(0, 7);
            default: en = 8'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0:       w = 0;
            1:       w = int'(TO);
            default: w = $urandom_range(1, 6);
         endcase
         do_txn(en, w);
      end

      for (int t = 0; t < 260; t++) do_txn(8'h00, 0);
      check_eq("err_saturated", 32'(bif.err_count), 32'd255);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
